turfio_rxclk_ps_ctrl: RTL
=========================

# turfio_rxclk_ps_ctrl

Phase-shift and lock controller for the TURFIO RXCLK MMCM. It runs in the PSCLK domain and drives the MMCM's RST, PSEN and PSINCDEC=1 inputs, and consumes its LOCKED and PSDONE outputs. It turns software requests ("reset MMCM", "advance phase by N fine steps") into correctly handshaked MMCM operations. It tracks the accumulated phase modulo one RXCLK period and reports timeouts and lock loss.

## Interface
Parameters:
- RST_CYCLES, 16: MMCM reset pulse width in clk_i cycles; must be ≥1.
- LOCK_TIMEOUT, 1048576: cycles to wait for lock before retrying the reset.
- PS_TIMEOUT, 64: cycles to wait for ps_done_i after ps_en_o.
- PS_WRAP, 672: fine steps per RXCLK period (VCO 1500 MHz, 56 steps per VCO period, 8 ns input).
- PHASE_BITS, 10: width of the phase counter and the step count; 2^PHASE_BITS must be ≥ PS_WRAP.

Ports:
- ps_clk_i  in  1  PSCLK; the only clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mmcm_rst_req_i  in  1  single-cycle request to reset the MMCM.
- ps_req_i  in  1  single-cycle request to shift the phase.
- ps_count_i  in  PHASE_BITS  number of increment steps, sampled with ps_req_i.
- mmcm_locked_i  in  1  MMCM LOCKED; asynchronous to ps_clk_i.
- ps_done_i  in  1  MMCM PSDONE.
- mmcm_rst_o  out  1  to MMCM RST.
- ps_en_o  out  1  to MMCM PSEN.
- locked_o  out  1  synchronized lock.
- busy_o  out  1  high when not in IDLE.
- phase_o  out  PHASE_BITS  accumulated phase, 0..PS_WRAP-1.
- lock_err_o  out  1  sticky: lock timeout occurred.
- ps_err_o  out  1  sticky: PSDONE timeout occurred.
- lock_lost_o  out  1  sticky: lock dropped while locked.
- err_clr_i  in  1  clears all three sticky flags.

## Operation
- mmcm_locked_i is synchronized through a 2-FF chain (ASYNC_REG) to produce locked_o. All logic uses locked_o.
- Reset values: state RESET_MMCM, mmcm_rst_o=1, ps_en_o=0, locked_o=0, busy_o=1, phase_o=0, all sticky flags 0, all counters 0.
- RESET_MMCM:
  - mmcm_rst_o=1 for RST_CYCLES cycles.
  - phase_o is forced to 0, because an MMCM reset clears the phase offset.
  - Then go to WAIT_LOCK.
- WAIT_LOCK:
  - When locked_o=1, go to IDLE.
  - After LOCK_TIMEOUT cycles without lock, set lock_err_o and go to RESET_MMCM (retry indefinitely).
- IDLE:
  - busy_o=0.
  - On ps_req_i, load remaining=ps_count_i. If the count is 0, stay in IDLE (no-op); otherwise go to PS_ISSUE.
- PS_ISSUE: ps_en_o=1 for exactly this one cycle, then go to PS_WAIT and clear the timeout counter.
- PS_WAIT:
  - On ps_done_i: phase_o ← phase_o+1, wrapping PS_WRAP-1→0; remaining ← remaining-1. If the new remaining is 0, go to IDLE; otherwise go to PS_ISSUE.
  - After PS_TIMEOUT cycles without ps_done_i, set ps_err_o and go to RESET_MMCM.
- Global priorities, highest first:
  1. rst_i.
  2. mmcm_rst_req_i: go to RESET_MMCM from any state and restart the reset pulse count if already in RESET_MMCM.
  3. Lock loss: locked_o falling in IDLE, PS_ISSUE or PS_WAIT sets lock_lost_o and goes to RESET_MMCM.
  4. Normal transitions.
- ps_req_i while busy is ignored; there is no queue.
- ps_done_i outside PS_WAIT is ignored.
- ps_done_i in the same cycle as mmcm_rst_req_i: the reset wins and phase_o goes to 0 with no increment.
- Sticky flags: err_clr_i clears them. If a set and err_clr_i occur in the same cycle, the set wins.
- PSINCDEC is tied to 1 at the MMCM, so all shifts are increments.

## Timing
- All outputs are registered. mmcm_rst_o and ps_en_o are Moore outputs of the state register.
- locked_o lags mmcm_locked_i by 2 clk_i cycles, plus metastability uncertainty.
- ps_req_i sampled at edge E (IDLE, count≠0): ps_en_o is high in the cycle after E, and busy_o goes high in the same cycle.
- ps_done_i sampled at edge D: phase_o updates after D. If steps remain, ps_en_o is high in the cycle after D, giving a minimum of 2 cycles between PSEN pulses. Otherwise busy_o drops after D.
- The timeout counter counts cycles in PS_WAIT. A timeout fires at the PS_TIMEOUT-th cycle without done.
- Reset pulse: mmcm_rst_o is high for exactly RST_CYCLES cycles per entry into RESET_MMCM, and is extended only by a new mmcm_rst_req_i.
- rst_i assertion is immediate. On release, the first RESET_MMCM cycle counts toward RST_CYCLES.

## Test plan
- Power-up: release rst_i, and the MMCM model raises lock 100 cycles after its reset falls. Expect mmcm_rst_o high for 16 cycles, locked_o 2 cycles after lock, busy_o=0, phase_o=0.
- Shift: ps_req_i with ps_count_i=5, PSDONE model returns 12 cycles after PSEN. Expect exactly 5 single-cycle ps_en_o pulses, phase_o=5, busy_o falls after the 5th done.
- Wrap: shift 670 then 5. Expect phase_o=3 and no ps_err_o.
- PSDONE timeout: the model never returns done. Expect ps_err_o set 64 cycles after ps_en_o, a new 16-cycle mmcm_rst_o, phase_o=0. Pulsing err_clr_i then clears ps_err_o.
- Lock loss mid-shift: drop lock during PS_WAIT. Expect lock_lost_o=1, state RESET_MMCM, phase_o=0. A ps_req_i issued while busy produces no extra ps_en_o.
- Collision: ps_done_i in the same cycle as mmcm_rst_req_i, and err_clr_i in the same cycle as a lock timeout. Expect phase_o=0 with no increment, and lock_err_o=1 (set wins).

Source files
------------

// File: rtl/turfio_rxclk_ps_ctrl_if.sv
// turfio_rxclk_ps_ctrl_if: software request/status and MMCM handshake signals of the RXCLK phase-shift controller
interface turfio_rxclk_ps_ctrl_if #(
    parameter int PHASE_BITS = 10
);
    logic                  mmcm_rst_req_i;
    logic                  ps_req_i;
    logic [PHASE_BITS-1:0] ps_count_i;
    logic                  mmcm_locked_i;
    logic                  ps_done_i;
    logic                  err_clr_i;
    logic                  mmcm_rst_o;
    logic                  ps_en_o;
    logic                  locked_o;
    logic                  busy_o;
    logic [PHASE_BITS-1:0] phase_o;
    logic                  lock_err_o;
    logic                  ps_err_o;
    logic                  lock_lost_o;
    modport master (
        output mmcm_rst_req_i, ps_req_i, ps_count_i, mmcm_locked_i, ps_done_i, err_clr_i,
        input  mmcm_rst_o, ps_en_o, locked_o, busy_o, phase_o, lock_err_o, ps_err_o, lock_lost_o
    );
    modport slave (
        input  mmcm_rst_req_i, ps_req_i, ps_count_i, mmcm_locked_i, ps_done_i, err_clr_i,
        output mmcm_rst_o, ps_en_o, locked_o, busy_o, phase_o, lock_err_o, ps_err_o, lock_lost_o
    );
endinterface

// File: rtl/turfio_rxclk_ps_ctrl.sv
// turfio_rxclk_ps_ctrl: RXCLK MMCM reset/lock sequencing and fine phase-shift stepping in the PSCLK domain
module turfio_rxclk_ps_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int PS_TIMEOUT   = 64,
    parameter int PS_WRAP      = 672,
    parameter int PHASE_BITS   = 10
) (
    input logic                   ps_clk_i,
    input logic                   rst_i,
    turfio_rxclk_ps_ctrl_if.slave bus
);
    localparam int MAX_A = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int MAX_CNT = (MAX_A > PS_TIMEOUT) ? MAX_A : PS_TIMEOUT;
    localparam int CW = $clog2(MAX_CNT + 1);
    typedef enum logic [2:0] {RESET_MMCM, WAIT_LOCK, IDLE, PS_ISSUE, PS_WAIT} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PHASE_BITS-1:0] rem_q, rem_d, phase_q, phase_d;
    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;
    logic                  lock_err_q, lock_err_d, ps_err_q, ps_err_d, lost_q, lost_d;
    logic                  locked, lost, lock_to, ps_to;
    assign locked = sync_q[1];
    assign lost = !locked && (state_q inside {IDLE, PS_ISSUE, PS_WAIT});
    // One shared counter: reset pulse width, lock wait and PSDONE wait never overlap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        lock_to = 1'b0;
        ps_to   = 1'b0;
        if (bus.mmcm_rst_req_i) begin
            state_d = RESET_MMCM;
            cnt_d   = '0;
        end else if (lost) begin
            state_d = RESET_MMCM;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RESET_MMCM: begin
                    cnt_d   = (cnt_q == CW'(RST_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET_MMCM;
                end
                WAIT_LOCK: begin
                    lock_to = !locked && (cnt_q == CW'(LOCK_TIMEOUT - 1));
                    cnt_d   = (locked || lock_to) ? '0 : cnt_q + 1'b1;
                    state_d = locked ? IDLE : lock_to ? RESET_MMCM : WAIT_LOCK;
                end
                IDLE: begin
                    if (bus.ps_req_i) begin
                        rem_d   = bus.ps_count_i;
                        state_d = (bus.ps_count_i != '0) ? PS_ISSUE : IDLE;
                    end
                end
                PS_ISSUE: begin
                    state_d = PS_WAIT;
                    cnt_d   = '0;
                end
                PS_WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.ps_done_i) begin
                        phase_d = (phase_q == PHASE_BITS'(PS_WRAP - 1)) ? '0 : phase_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        state_d = (rem_q == PHASE_BITS'(1)) ? IDLE : PS_ISSUE;
                    end else if (cnt_q == CW'(PS_TIMEOUT - 1)) begin
                        ps_to   = 1'b1;
                        state_d = RESET_MMCM;
                        cnt_d   = '0;
                    end
                end
                default: state_d = RESET_MMCM;
            endcase
        end
        // An MMCM reset discards the accumulated phase offset
        if (state_d == RESET_MMCM) phase_d = '0;
        lock_err_d = lock_to || (lock_err_q && !bus.err_clr_i);
        ps_err_d   = ps_to || (ps_err_q && !bus.err_clr_i);
        lost_d     = (lost && !bus.mmcm_rst_req_i) || (lost_q && !bus.err_clr_i);
    end
    always_ff @(posedge ps_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RESET_MMCM;
            cnt_q      <= '0;
            rem_q      <= '0;
            phase_q    <= '0;
            sync_q     <= '0;
            lock_err_q <= 1'b0;
            ps_err_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            phase_q    <= phase_d;
            sync_q     <= {sync_q[0], bus.mmcm_locked_i};
            lock_err_q <= lock_err_d;
            ps_err_q   <= ps_err_d;
            lost_q     <= lost_d;
        end
    end
    assign bus.mmcm_rst_o  = (state_q == RESET_MMCM);
    assign bus.ps_en_o     = (state_q == PS_ISSUE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.locked_o    = locked;
    assign bus.phase_o     = phase_q;
    assign bus.lock_err_o  = lock_err_q;
    assign bus.ps_err_o    = ps_err_q;
    assign bus.lock_lost_o = lost_q;
endmodule
